change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_dispenser.sv | 134 +++++++++++++
 tb/tb_change_dispenser.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Vending-machine change dispenser: pulses the soda solenoid, then pays owed change as dimes/nickels
// through a 4-phase hopper handshake. Define CHANGE_DISPENSER_TIMEOUT_EN to add the hopper timeout/FAULT.
module change_dispenser #(
  parameter int SODA_PULSE_CYC = 4,
  parameter int ACK_TIMEOUT    = 255
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_soda,
  input  logic [2:0] i_change,
  input  logic       i_dime_empty,
  input  logic       i_coin_ack,
  output logic       o_soda_eject,
  output logic       o_dime_req,
  output logic       o_nickel_req,
  output logic       o_busy,
  output logic       o_done,
  output logic [2:0] o_remaining,
  output logic       o_fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SODA,
    S_SELECT,
    S_REQ,
    S_ACK_LOW,
    S_DONE
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
    , S_FAULT
`endif
  } state_e;

  localparam logic [7:0] SODA_LAST = 8'(SODA_PULSE_CYC - 1);
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
  localparam logic [7:0] ACK_LAST  = 8'(ACK_TIMEOUT - 1);
`endif

  state_e     state_q, state_d;
  logic [2:0] remaining_q, remaining_d;
  logic [7:0] timer_q, timer_d;
  logic       dime_q, dime_d;

  // NOTE: every always_comb target gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    timer_d     = timer_q;
    dime_d      = dime_q;
    case (state_q)
      S_IDLE: begin
        if (i_soda) begin
          remaining_d = (i_change > 3'd4) ? 3'd4 : i_change;
          timer_d     = '0;
          state_d     = S_SODA;
        end
      end
      S_SODA: begin
        if (timer_q == SODA_LAST) begin
          timer_d = '0;
          state_d = S_SELECT;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_SELECT: begin
        // Coin type is frozen here; later changes on i_dime_empty cannot alter a pending request.
        if (remaining_q == 3'd0) begin
          state_d = S_DONE;
        end else begin
          dime_d  = (remaining_q >= 3'd2) && !i_dime_empty;
          timer_d = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (i_coin_ack) begin
          if (dime_q) remaining_d = (remaining_q >= 3'd2) ? remaining_q - 3'd2 : 3'd0;
          else        remaining_d = (remaining_q >= 3'd1) ? remaining_q - 3'd1 : 3'd0;
          timer_d = '0;
          state_d = S_ACK_LOW;
        end
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
        else if (timer_q == ACK_LAST) state_d = S_FAULT;
        else                          timer_d = timer_q + 8'd1;
`endif
      end
      S_ACK_LOW: begin
        if (!i_coin_ack) begin
          timer_d = '0;
          state_d = S_SELECT;
        end
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
        else if (timer_q == ACK_LAST) state_d = S_FAULT;
        else                          timer_d = timer_q + 8'd1;
`endif
      end
      S_DONE: state_d = S_IDLE;
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
      S_FAULT: state_d = S_FAULT;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      timer_q     <= '0;
      dime_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      timer_q     <= timer_d;
      dime_q      <= dime_d;
    end
  end

  assign o_soda_eject = (state_q == S_SODA);
  assign o_dime_req   = (state_q == S_REQ) &&  dime_q;
  assign o_nickel_req = (state_q == S_REQ) && !dime_q;
  assign o_done       = (state_q == S_DONE);
  assign o_remaining  = remaining_q;
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
  assign o_busy  = (state_q != S_IDLE) && (state_q != S_FAULT);
  assign o_fault = (state_q == S_FAULT);
`else
  assign o_busy  = (state_q != S_IDLE);
  assign o_fault = 1'b0;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser; the timeout scenario runs only when
// CHANGE_DISPENSER_TIMEOUT_EN is defined (DUT built with ACK_TIMEOUT=8).
module tb_change_dispenser;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_soda;
  logic [2:0] i_change;
  logic       i_dime_empty;
  logic       i_coin_ack;
  logic       o_soda_eject, o_dime_req, o_nickel_req, o_busy, o_done, o_fault;
  logic [2:0] o_remaining;

  int checks   = 0;
  int failures = 0;

  // Per-vend observations gathered by run_vend.
  int          r_soda, r_dimes, r_nickels, r_dones, r_busy, r_both;
  logic [7:0]  r_coin_log;
  logic [14:0] r_rem_log;
  bit          r_timeout;

  change_dispenser #(.SODA_PULSE_CYC(4), .ACK_TIMEOUT(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_soda(i_soda), .i_change(i_change),
    .i_dime_empty(i_dime_empty), .i_coin_ack(i_coin_ack),
    .o_soda_eject(o_soda_eject), .o_dime_req(o_dime_req), .o_nickel_req(o_nickel_req),
    .o_busy(o_busy), .o_done(o_done), .o_remaining(o_remaining), .o_fault(o_fault)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Starts a vend from IDLE and plays the hopper (ack two samples after each request rises).
  task automatic run_vend(input logic [2:0] chg, input logic dempty, input bit inject, input bit flip);
    logic [2:0] last_rem;
    int  req_age;
    bit  injected, done_seen, finished;
    r_soda = 0; r_dimes = 0; r_nickels = 0; r_dones = 0; r_busy = 0; r_both = 0;
    r_coin_log = '0; r_rem_log = '0;
    req_age = 0; injected = 0; done_seen = 0; finished = 0;
    last_rem = o_remaining;
    i_soda = 1'b1; i_change = chg; i_dime_empty = dempty; i_coin_ack = 1'b0;
    tick();
    i_soda = 1'b0; i_change = 3'd0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (o_busy) r_busy++;
      if (o_soda_eject) r_soda++;
      if (o_done) begin r_dones++; done_seen = 1; end
      if (o_remaining !== last_rem) begin
        r_rem_log = {r_rem_log[11:0], o_remaining};
        last_rem  = o_remaining;
      end
      if (o_dime_req && o_nickel_req) r_both++;
      if (o_dime_req || o_nickel_req) begin
        if (req_age == 0) begin
          r_coin_log = {r_coin_log[6:0], o_dime_req};
          if (o_dime_req) r_dimes++; else r_nickels++;
        end
        req_age++;
        if (req_age >= 2) i_coin_ack = 1'b1;
        if (inject && !injected) begin i_soda = 1'b1; i_change = 3'd2; injected = 1; end
        if (flip) i_dime_empty = ~dempty;
      end else begin
        req_age = 0;
        i_coin_ack = 1'b0;
      end
      if (done_seen && !o_busy) begin finished = 1; break; end
      tick();
      i_soda = 1'b0;
    end
    r_timeout = !finished;
    i_dime_empty = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_soda = 1'b0; i_change = 3'd0; i_dime_empty = 1'b0; i_coin_ack = 1'b0;
    tick(); tick();
    checks++; if ({o_soda_eject, o_dime_req, o_nickel_req, o_busy, o_done, o_fault} !== 6'b0) begin
      failures++; $display("FAIL reset_flags: got %b expected 000000",
        {o_soda_eject, o_dime_req, o_nickel_req, o_busy, o_done, o_fault}); end
    checks++; if (o_remaining !== 3'd0) begin failures++; $display("FAIL reset_remaining: got %0d expected 0", o_remaining); end
    i_rst = 1'b0;
    tick();
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b expected 0", o_busy); end
  endtask

  task automatic test_dime_nickel();
    i_soda = 1'b1; i_change = 3'd3;
    tick();
    i_soda = 1'b0;
    checks++; if (o_busy !== 1'b1 || o_soda_eject !== 1'b1 || o_remaining !== 3'd3) begin failures++;
      $display("FAIL accept: busy=%b soda=%b rem=%0d expected 1 1 3", o_busy, o_soda_eject, o_remaining); end
    // Return to IDLE via a fresh reset so the full vend below starts from a clean state.
    i_rst = 1'b1; tick(); i_rst = 1'b0;
    run_vend(3'd3, 1'b0, 0, 0);
    checks++; if (r_timeout) begin failures++; $display("FAIL v3_finish: got timeout expected completion"); end
    checks++; if (r_soda !== 4) begin failures++; $display("FAIL v3_soda_cycles: got %0d expected 4", r_soda); end
    checks++; if (r_dimes !== 1 || r_nickels !== 1) begin failures++;
      $display("FAIL v3_coins: got dimes=%0d nickels=%0d expected 1 1", r_dimes, r_nickels); end
    checks++; if (r_coin_log[1:0] !== 2'b10) begin failures++; $display("FAIL v3_order: got %b expected 10", r_coin_log[1:0]); end
    checks++; if (r_rem_log !== 15'o00310) begin failures++; $display("FAIL v3_remaining: got %o expected 00310", r_rem_log); end
    checks++; if (r_dones !== 1) begin failures++; $display("FAIL v3_done: got %0d expected 1", r_dones); end
    checks++; if (r_busy !== 14) begin failures++; $display("FAIL v3_busy_cycles: got %0d expected 14", r_busy); end
    checks++; if (r_both !== 0) begin failures++; $display("FAIL v3_both_req: got %0d expected 0", r_both); end
  endtask

  task automatic test_nickels_only();
    run_vend(3'd4, 1'b1, 0, 0);
    checks++; if (r_dimes !== 0 || r_nickels !== 4) begin failures++;
      $display("FAIL empty_coins: got dimes=%0d nickels=%0d expected 0 4", r_dimes, r_nickels); end
    checks++; if (r_rem_log !== 15'o43210) begin failures++; $display("FAIL empty_remaining: got %o expected 43210", r_rem_log); end
    checks++; if (r_dones !== 1 || r_timeout) begin failures++; $display("FAIL empty_done: got %0d expected 1", r_dones); end
    run_vend(3'd4, 1'b0, 0, 0);
    checks++; if (r_dimes !== 2 || r_nickels !== 0) begin failures++;
      $display("FAIL four_coins: got dimes=%0d nickels=%0d expected 2 0", r_dimes, r_nickels); end
    checks++; if (r_rem_log !== 15'o00420) begin failures++; $display("FAIL four_remaining: got %o expected 00420", r_rem_log); end
  endtask

  task automatic test_boundaries();
    run_vend(3'd0, 1'b0, 0, 0);
    checks++; if (r_soda !== 4 || r_dimes + r_nickels !== 0) begin failures++;
      $display("FAIL zero_change: got soda=%0d coins=%0d expected 4 0", r_soda, r_dimes + r_nickels); end
    checks++; if (r_dones !== 1 || r_busy !== 6) begin failures++;
      $display("FAIL zero_done: got done=%0d busy=%0d expected 1 6", r_dones, r_busy); end
    run_vend(3'd7, 1'b1, 0, 0);
    checks++; if (r_nickels !== 4 || r_dimes !== 0 || r_dones !== 1) begin failures++;
      $display("FAIL clamp7_coins: got n=%0d d=%0d done=%0d expected 4 0 1", r_nickels, r_dimes, r_dones); end
    checks++; if (r_rem_log !== 15'o43210) begin failures++; $display("FAIL clamp7_remaining: got %o expected 43210", r_rem_log); end
  endtask

  task automatic test_ignore_soda();
    run_vend(3'd2, 1'b0, 1, 1);
    checks++; if (r_dones !== 1) begin failures++; $display("FAIL ignore_done: got %0d expected 1", r_dones); end
    checks++; if (r_dimes !== 1 || r_nickels !== 0) begin failures++;
      $display("FAIL ignore_coin: got dimes=%0d nickels=%0d expected 1 0", r_dimes, r_nickels); end
    checks++; if (r_rem_log !== 15'o00020) begin failures++; $display("FAIL ignore_remaining: got %o expected 00020", r_rem_log); end
    tick(); tick();
    checks++; if (o_busy !== 1'b0 || o_soda_eject !== 1'b0) begin failures++;
      $display("FAIL ignore_idle: got busy=%b soda=%b expected 0 0", o_busy, o_soda_eject); end
  endtask

  task automatic test_back_to_back();
    run_vend(3'd0, 1'b0, 0, 0);
    run_vend(3'd1, 1'b0, 0, 0);
    checks++; if (r_soda !== 4 || r_nickels !== 1 || r_dones !== 1 || r_timeout) begin failures++;
      $display("FAIL b2b_second: got soda=%0d n=%0d done=%0d expected 4 1 1", r_soda, r_nickels, r_dones); end
  endtask

  task automatic test_reset_mid();
    bit in_ack_low;
    int dones;
    in_ack_low = 0; dones = 0;
    i_soda = 1'b1; i_change = 3'd2; i_dime_empty = 1'b0; i_coin_ack = 1'b0;
    tick();
    i_soda = 1'b0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      if (o_dime_req || o_nickel_req) i_coin_ack = 1'b1;
      else if (i_coin_ack && o_busy) begin in_ack_low = 1; break; end
      tick();
    end
    checks++; if (!in_ack_low) begin failures++; $display("FAIL rstmid_reach: got no ACK_LOW expected ACK_LOW"); end
    i_rst = 1'b1;
    tick();
    checks++; if ({o_soda_eject, o_dime_req, o_nickel_req, o_busy, o_done, o_fault, o_remaining} !== 9'b0) begin
      failures++; $display("FAIL rstmid_outputs: got %b expected 000000000",
        {o_soda_eject, o_dime_req, o_nickel_req, o_busy, o_done, o_fault, o_remaining}); end
    i_rst = 1'b0; i_coin_ack = 1'b0;
    for (int k = 0; k < 5; k++) begin tick(); if (o_done) dones++; end
    checks++; if (dones !== 0) begin failures++; $display("FAIL rstmid_no_done: got %0d expected 0", dones); end
    run_vend(3'd1, 1'b0, 0, 0);
    checks++; if (r_nickels !== 1 || r_dones !== 1 || r_timeout) begin failures++;
      $display("FAIL rstmid_revend: got n=%0d done=%0d expected 1 1", r_nickels, r_dones); end
  endtask

`ifdef CHANGE_DISPENSER_TIMEOUT_EN
  task automatic test_timeout();
    int req_cyc;
    req_cyc = 0;
    i_soda = 1'b1; i_change = 3'd1; i_coin_ack = 1'b0;
    tick();
    i_soda = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (o_fault) break;
      if (o_nickel_req || o_dime_req) req_cyc++;
      tick();
    end
    checks++; if (req_cyc !== 8) begin failures++; $display("FAIL tmo_req_cycles: got %0d expected 8", req_cyc); end
    checks++; if ({o_fault, o_dime_req, o_nickel_req, o_busy} !== 4'b1000) begin failures++;
      $display("FAIL tmo_outputs: got %b expected 1000", {o_fault, o_dime_req, o_nickel_req, o_busy}); end
    i_coin_ack = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    i_coin_ack = 1'b0;
    checks++; if (o_fault !== 1'b1) begin failures++; $display("FAIL tmo_sticky: got %b expected 1", o_fault); end
    i_rst = 1'b1; tick(); i_rst = 1'b0;
    checks++; if (o_fault !== 1'b0) begin failures++; $display("FAIL tmo_clear: got %b expected 0", o_fault); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_dime_nickel();
    test_nickels_only();
    test_boundaries();
    test_ignore_soda();
    test_back_to_back();
    test_reset_mid();
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
